// File: rtl/ex_stage_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ex_stage_unit
//
// Execute stage of the pipeline. It takes the ID/EX register outputs and
// produces the registered EX/MEM payload. It contains:
//   - a single-cycle ALU (add/sub/logic/compare/shift/LUI, MFHI/MFLO),
//   - branch resolution (taken flag + target, registered with the payload),
//   - a multi-cycle MULTU/DIVU engine (shift-add / restoring divide) that
//     owns the HI/LO registers and asks IF/ID and ID/EX to hold via stall.
// All state changes on the falling edge of clk. reset is asynchronous and
// active-low.
//
// Ports
//   clk            pipeline clock (falling-edge active)
//   reset          async reset, asserted low
//   flush          kill: EX/MEM gets a bubble, multi-cycle op aborted
//   RegWriteIn, MemReadIn, MemWriteIn   control fields from ID/EX
//   ALUOp[3:0]     operation select
//   NotEqual, IsBranch                  branch control from ID/EX
//   ALUVal1, ALUVal2, readReg2, branchAddr  operands, store data, target
//   dest[4:0]      destination register
//   RegWrite, MemRead, MemWrite         registered EX/MEM control
//   ALUResult, storeData                registered result / store data
//   destOut[4:0]   registered destination
//   branchTaken, branchTarget           registered branch outcome
//   stall          combinational hold request for IF/ID and ID/EX
//   busy           multi-cycle engine active
// ---------------------------------------------------------------------------
module ex_stage_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             RegWriteIn,
    input  logic             MemReadIn,
    input  logic             MemWriteIn,
    input  logic [3:0]       ALUOp,
    input  logic             NotEqual,
    input  logic             IsBranch,
    input  logic [WIDTH-1:0] ALUVal1,
    input  logic [WIDTH-1:0] ALUVal2,
    input  logic [WIDTH-1:0] readReg2,
    input  logic [WIDTH-1:0] branchAddr,
    input  logic [4:0]       dest,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] storeData,
    output logic [4:0]       destOut,
    output logic             branchTaken,
    output logic [WIDTH-1:0] branchTarget,
    output logic             stall,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_stall;

    // Architectural HI/LO and the engine's working registers. The working
    // copy is only committed on the DONE edge, so an aborted op never
    // disturbs HI/LO.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_work_hi;
    logic [WIDTH-1:0] r_work_lo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_is_div;
    logic [CW-1:0]    r_cnt;

    // EX/MEM payload registers
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [WIDTH-1:0] r_alu_result;
    logic [WIDTH-1:0] r_store_data;
    logic [4:0]       r_dest;
    logic             r_branch_taken;
    logic [WIDTH-1:0] r_branch_target;

    logic             w_is_mdu;
    logic             w_bubble;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_branch_taken;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_work_hi_next;
    logic [WIDTH-1:0] w_work_lo_next;

    assign w_is_mdu = (ALUOp == OP_MULTU) || (ALUOp == OP_DIVU);
    assign w_shamt  = ALUVal1[SHW-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state / stall ----------------
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mdu && !flush) begin
                    w_state_next = S_RUN;
                    w_stall      = 1'b1;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == CW'(ITER - 1)) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // stall is forced low while reset is held so nothing upstream freezes.
    assign stall = reset & w_stall;
    assign busy  = (r_state != S_IDLE);

    // ---------------- Single-cycle ALU ----------------
    always_comb begin
        w_alu_result = '0;
        case (ALUOp)
            OP_ADD:  w_alu_result = ALUVal1 + ALUVal2;
            OP_SUB:  w_alu_result = ALUVal1 - ALUVal2;
            OP_AND:  w_alu_result = ALUVal1 & ALUVal2;
            OP_OR:   w_alu_result = ALUVal1 | ALUVal2;
            OP_XOR:  w_alu_result = ALUVal1 ^ ALUVal2;
            OP_NOR:  w_alu_result = ~(ALUVal1 | ALUVal2);
            OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(ALUVal1) < $signed(ALUVal2))};
            OP_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, (ALUVal1 < ALUVal2)};
            OP_SLL:  w_alu_result = ALUVal2 << w_shamt;
            OP_SRL:  w_alu_result = ALUVal2 >> w_shamt;
            OP_SRA:  w_alu_result = $unsigned($signed(ALUVal2) >>> w_shamt);
            OP_LUI:  w_alu_result = ALUVal2 << 16;
            OP_MFHI: w_alu_result = r_hi;
            OP_MFLO: w_alu_result = r_lo;
            default: w_alu_result = '0;
        endcase
    end

    assign w_branch_taken = IsBranch & ((ALUVal1 == ALUVal2) ^ NotEqual);

    // Anything other than a single-cycle op issued from IDLE is a bubble.
    assign w_bubble = flush || (r_state != S_IDLE) || w_is_mdu;

    // ---------------- MULTU / DIVU step ----------------
    // MULTU: {work_hi, work_lo} starts as {0, multiplier}; each step adds
    // the multiplicand when the low bit is set and shifts the 65-bit
    // pair right. DIVU: work_lo holds the dividend and fills with quotient
    // bits from the right, work_hi is the partial remainder. With a zero
    // divisor every step "succeeds", giving LO = all ones, HI = dividend.
    assign w_mul_sum   = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_divisor} : '0);
    assign w_div_shift = {r_work_hi, r_work_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_divisor});
    // The true difference is below the divisor whenever it is used, so
    // WIDTH bits are enough.
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_divisor;

    always_comb begin
        w_work_hi_next = r_work_hi;
        w_work_lo_next = r_work_lo;
        if (r_is_div) begin
            w_work_hi_next = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            w_work_lo_next = {r_work_lo[WIDTH-2:0], w_div_ge};
        end else begin
            w_work_hi_next = w_mul_sum[WIDTH:1];
            w_work_lo_next = {w_mul_sum[0], r_work_lo[WIDTH-1:1]};
        end
    end

    // ---------------- Engine datapath and HI/LO ----------------
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_work_hi <= '0;
            r_work_lo <= '0;
            r_divisor <= '0;
            r_is_div  <= 1'b0;
            r_cnt     <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mdu) begin
                        r_work_hi <= '0;
                        r_work_lo <= ALUVal1;
                        r_divisor <= ALUVal2;
                        r_is_div  <= (ALUOp == OP_DIVU);
                        r_cnt     <= '0;
                    end
                end
                S_RUN: begin
                    r_work_hi <= w_work_hi_next;
                    r_work_lo <= w_work_lo_next;
                    r_cnt     <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_hi <= r_work_hi;
                    r_lo <= r_work_lo;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // ---------------- EX/MEM payload ----------------
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_alu_result    <= '0;
            r_store_data    <= '0;
            r_dest          <= '0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
        end else if (w_bubble) begin
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_alu_result    <= '0;
            r_store_data    <= '0;
            r_dest          <= '0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
        end else begin
            r_reg_write     <= RegWriteIn;
            r_mem_read      <= MemReadIn;
            r_mem_write     <= MemWriteIn;
            r_alu_result    <= w_alu_result;
            r_store_data    <= readReg2;
            r_dest          <= dest;
            r_branch_taken  <= w_branch_taken;
            r_branch_target <= branchAddr;
        end
    end

    assign RegWrite     = r_reg_write;
    assign MemRead      = r_mem_read;
    assign MemWrite     = r_mem_write;
    assign ALUResult    = r_alu_result;
    assign storeData    = r_store_data;
    assign destOut      = r_dest;
    assign branchTaken  = r_branch_taken;
    assign branchTarget = r_branch_target;

endmodule

// File: tb/tb_ex_stage_unit.sv
`timescale 1ns/1ps
// Bench for ex_stage_unit. The DUT acts on falling edges; inputs are driven
// 1 ns after each rising edge, combinational outputs are checked 1 ns before
// the falling edge and registered outputs 1 ns after it.
module tb_ex_stage_unit;

    localparam int W    = 32;
    localparam int ITER = 32;

    logic          clk = 1'b1;
    logic          reset;
    logic          flush;
    logic          RegWriteIn, MemReadIn, MemWriteIn;
    logic [3:0]    ALUOp;
    logic          NotEqual, IsBranch;
    logic [W-1:0]  ALUVal1, ALUVal2, readReg2, branchAddr;
    logic [4:0]    dest;
    logic          RegWrite, MemRead, MemWrite;
    logic [W-1:0]  ALUResult, storeData;
    logic [4:0]    destOut;
    logic          branchTaken;
    logic [W-1:0]  branchTarget;
    logic          stall, busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic last_stall;

    always #5 clk = ~clk;

    ex_stage_unit #(.WIDTH(W), .ITER(ITER)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .ALUOp(ALUOp), .NotEqual(NotEqual), .IsBranch(IsBranch),
        .ALUVal1(ALUVal1), .ALUVal2(ALUVal2), .readReg2(readReg2),
        .branchAddr(branchAddr), .dest(dest),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUResult(ALUResult), .storeData(storeData), .destOut(destOut),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .stall(stall), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
        logic signed [31:0] sb;
        sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << a[4:0];
            4'd9:  return b >> a[4:0];
            4'd10: return sb >>> a[4:0];
            4'd11: return {b[15:0], 16'h0000};
            4'd14: return hi;
            4'd15: return lo;
            default: return 32'd0;
        endcase
    endfunction

    // m_cnt = number of edges since a MULTU/DIVU started (0 = no op active).
    int          m_cnt = 0;
    logic [31:0] m_a, m_b, m_hi, m_lo;
    bit          m_div;

    initial begin : compare_proc
        logic        e_stall, e_busy, e_full;
        logic        e_rw, e_mr, e_mw, e_bt;
        logic [31:0] e_res, e_sd, e_tgt;
        logic [4:0]  e_dest;
        logic [63:0] prod;
        logic        start;
        m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_div = 0;
        forever begin
            @(posedge clk);
            #4;
            e_full = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_bt = 0;
            e_res = 0; e_sd = 0; e_tgt = 0; e_dest = 0;
            if (!reset) begin
                m_cnt = 0; m_hi = 0; m_lo = 0;
                chk("m_stall_rst", {63'd0, stall}, 64'd0);
                chk("m_busy_rst", {63'd0, busy}, 64'd0);
                e_full = 1;
            end else begin
                start   = (m_cnt == 0) && (ALUOp == 4'd12 || ALUOp == 4'd13);
                e_stall = !flush && (start || (m_cnt >= 1 && m_cnt <= ITER));
                e_busy  = (m_cnt != 0);
                chk("m_stall", {63'd0, stall}, {63'd0, e_stall});
                chk("m_busy", {63'd0, busy}, {63'd0, e_busy});
                if (flush) begin
                    m_cnt = 0;
                end else if (start) begin
                    m_a = ALUVal1; m_b = ALUVal2; m_div = (ALUOp == 4'd13);
                    m_cnt = 1;
                end else if (m_cnt == ITER + 1) begin
                    if (!m_div) begin
                        prod = {32'd0, m_a} * {32'd0, m_b};
                        m_hi = prod[63:32]; m_lo = prod[31:0];
                    end else if (m_b == 0) begin
                        m_hi = m_a; m_lo = 32'hFFFF_FFFF;
                    end else begin
                        m_hi = m_a % m_b; m_lo = m_a / m_b;
                    end
                    m_cnt = 0;
                end else if (m_cnt != 0) begin
                    m_cnt++;
                end else begin
                    e_full = 1;
                    e_rw = RegWriteIn; e_mr = MemReadIn; e_mw = MemWriteIn;
                    e_bt = IsBranch & ((ALUVal1 == ALUVal2) ^ NotEqual);
                    e_res = ref_alu(ALUOp, ALUVal1, ALUVal2, m_hi, m_lo);
                    e_sd = readReg2; e_tgt = branchAddr; e_dest = dest;
                end
            end
            #2;
            chk("m_regwrite", {63'd0, RegWrite}, {63'd0, e_rw});
            chk("m_memread", {63'd0, MemRead}, {63'd0, e_mr});
            chk("m_memwrite", {63'd0, MemWrite}, {63'd0, e_mw});
            chk("m_btaken", {63'd0, branchTaken}, {63'd0, e_bt});
            if (e_full) begin
                chk("m_result", {32'd0, ALUResult}, {32'd0, e_res});
                chk("m_storedata", {32'd0, storeData}, {32'd0, e_sd});
                chk("m_dest", {59'd0, destOut}, {59'd0, e_dest});
                chk("m_btarget", {32'd0, branchTarget}, {32'd0, e_tgt});
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic set_in(input logic [3:0] op, input logic [31:0] v1, v2, rr2, baddr,
                          input logic [4:0] d, input logic rw, mr, mw, isb, ne);
        ALUOp = op; ALUVal1 = v1; ALUVal2 = v2; readReg2 = rr2; branchAddr = baddr;
        dest = d; RegWriteIn = rw; MemReadIn = mr; MemWriteIn = mw;
        IsBranch = isb; NotEqual = ne;
    endtask

    // Issue one single-cycle instruction; returns 1 ns after its capture edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] v1, v2, rr2, baddr,
                         input logic [4:0] d, input logic rw, mr, mw, isb, ne);
        @(posedge clk);
        #1;
        set_in(op, v1, v2, rr2, baddr, d, rw, mr, mw, isb, ne);
        #3 last_stall = stall;
        #2;
        $display("[%0t] op=%0d v1=0x%08h v2=0x%08h -> res=0x%08h rw=%0b dest=%0d bt=%0b",
                 $time, op, v1, v2, ALUResult, RegWrite, destOut, branchTaken);
    endtask

    // Issue MULTU/DIVU and hold it while stall is high. flush_at / reset_at
    // give the number of completed edges before flush or reset is applied
    // (-1 = never). n returns the number of edges that saw stall high.
    task automatic run_mdu(input logic [3:0] op, input logic [31:0] a, b,
                           input int flush_at, input int reset_at, output int n);
        logic s;
        bit   done;
        n = 0; done = 0;
        @(posedge clk);
        #1;
        set_in(op, a, b, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (n == flush_at) flush = 1'b1;
            if (n == reset_at) begin
                reset = 1'b0;
                #1;
                chk("rst_mid_busy", {63'd0, busy}, 64'd0);
                chk("rst_mid_stall", {63'd0, stall}, 64'd0);
                chk("rst_mid_regwrite", {63'd0, RegWrite}, 64'd0);
                @(posedge clk);
                #1;
                reset = 1'b1;
                set_in(4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                done = 1;
                break;
            end
            #3 s = stall;
            @(negedge clk);
            #1;
            if (!s) begin
                done = 1;
                break;
            end
            n++;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL mdu_timeout: stall still high after %0d edges, expected release", n);
        end
        $display("[%0t] mdu op=%0d a=0x%08h b=0x%08h stall_edges=%0d busy=%0b", $time, op, a, b, n, busy);
    endtask

    initial begin
        int n;
        reset = 1'b0; flush = 1'b0;
        set_in(4'd12, 32'h3, 32'h4, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #4;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", {32'd0, ALUResult}, 64'd0);
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        @(posedge clk);
        #1;
        set_in(4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        issue(4'd0, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3, 1, 0, 0, 0, 0);
        chk("add_result", {32'd0, ALUResult}, 64'd12);
        chk("add_dest", {59'd0, destOut}, 64'd3);
        chk("add_regwrite", {63'd0, RegWrite}, 64'd1);
        chk("add_stall", {63'd0, last_stall}, 64'd0);

        issue(4'd1, 32'd4, 32'd4, 32'h0, 32'h40, 5'd0, 0, 0, 0, 1, 1);
        chk("bne_eq_taken", {63'd0, branchTaken}, 64'd0);
        issue(4'd1, 32'd4, 32'd5, 32'h0, 32'h40, 5'd0, 0, 0, 0, 1, 1);
        chk("bne_ne_taken", {63'd0, branchTaken}, 64'd1);
        chk("bne_target", {32'd0, branchTarget}, 64'h40);

        issue(4'd1, 32'd3, 32'd5, 32'h0, 32'h0, 5'd4, 1, 0, 0, 0, 0);
        chk("sub_wrap", {32'd0, ALUResult}, 64'hFFFF_FFFE);
        issue(4'd6, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd5, 1, 0, 0, 0, 0);
        chk("slt_neg", {32'd0, ALUResult}, 64'd1);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd5, 1, 0, 0, 0, 0);
        chk("sltu_big", {32'd0, ALUResult}, 64'd0);
        issue(4'd10, 32'd4, 32'h8000_0000, 32'h0, 32'h0, 5'd6, 1, 0, 0, 0, 0);
        chk("sra", {32'd0, ALUResult}, 64'hF800_0000);
        issue(4'd9, 32'd4, 32'h8000_0000, 32'h0, 32'h0, 5'd6, 1, 0, 0, 0, 0);
        chk("srl", {32'd0, ALUResult}, 64'h0800_0000);
        issue(4'd8, 32'd31, 32'd1, 32'h0, 32'h0, 5'd6, 1, 0, 0, 0, 0);
        chk("sll", {32'd0, ALUResult}, 64'h8000_0000);
        issue(4'd11, 32'd0, 32'h1234, 32'h0, 32'h0, 5'd7, 1, 0, 0, 0, 0);
        chk("lui", {32'd0, ALUResult}, 64'h1234_0000);
        issue(4'd5, 32'd0, 32'd0, 32'h0, 32'h0, 5'd7, 1, 0, 0, 0, 0);
        chk("nor", {32'd0, ALUResult}, 64'hFFFF_FFFF);
        issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h0, 5'd8, 1, 0, 0, 0, 0);
        issue(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h0, 5'd8, 1, 0, 0, 0, 0);
        issue(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h0, 5'd8, 1, 0, 0, 0, 0);
        issue(4'd0, 32'h100, 32'h8, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0, 1, 0, 0);
        chk("sw_data", {32'd0, storeData}, 64'hDEAD_BEEF);
        chk("sw_memwrite", {63'd0, MemWrite}, 64'd1);

        run_mdu(4'd12, 32'hFFFF_FFFF, 32'd2, -1, -1, n);
        chk("multu_stall_edges", n, 64'd33);
        issue(4'd14, 32'd0, 32'd0, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0);
        chk("mfhi_mul", {32'd0, ALUResult}, 64'd1);
        issue(4'd15, 32'd0, 32'd0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 0);
        chk("mflo_mul", {32'd0, ALUResult}, 64'hFFFF_FFFE);

        run_mdu(4'd13, 32'd100, 32'd7, -1, -1, n);
        chk("divu_stall_edges", n, 64'd33);
        issue(4'd15, 32'd0, 32'd0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 0);
        chk("mflo_div", {32'd0, ALUResult}, 64'd14);
        issue(4'd14, 32'd0, 32'd0, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0);
        chk("mfhi_div", {32'd0, ALUResult}, 64'd2);

        run_mdu(4'd13, 32'd9, 32'd0, -1, -1, n);
        chk("div0_stall_edges", n, 64'd33);
        issue(4'd14, 32'd0, 32'd0, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0);
        chk("mfhi_div0", {32'd0, ALUResult}, 64'd9);
        issue(4'd15, 32'd0, 32'd0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 0);
        chk("mflo_div0", {32'd0, ALUResult}, 64'hFFFF_FFFF);

        run_mdu(4'd13, 32'd50, 32'd3, 5, -1, n);
        chk("flush_edges", n, 64'd5);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_regwrite", {63'd0, RegWrite}, 64'd0);
        issue(4'd14, 32'd0, 32'd0, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0);
        chk("mfhi_flush", {32'd0, ALUResult}, 64'd9);
        issue(4'd15, 32'd0, 32'd0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 0);
        chk("mflo_flush", {32'd0, ALUResult}, 64'hFFFF_FFFF);

        run_mdu(4'd12, 32'd3, 32'd4, -1, 10, n);
        issue(4'd14, 32'd0, 32'd0, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0);
        chk("mfhi_rst", {32'd0, ALUResult}, 64'd0);
        issue(4'd15, 32'd0, 32'd0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 0);
        chk("mflo_rst", {32'd0, ALUResult}, 64'd0);
        issue(4'd0, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3, 1, 0, 0, 0, 0);
        chk("add_after_rst", {32'd0, ALUResult}, 64'd12);

        run_mdu(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, -1, -1, n);
        issue(4'd14, 32'd0, 32'd0, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0);
        issue(4'd15, 32'd0, 32'd0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 0);
        run_mdu(4'd13, 32'hFFFF_FFFF, 32'h0001_0001, -1, -1, n);
        issue(4'd14, 32'd0, 32'd0, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0);
        issue(4'd15, 32'd0, 32'd0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 0);

        @(posedge clk);
        #8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_stage_unit.md
Name: ex_stage_unit

Overview:
- Execute stage that consumes the ID/EX pipeline register's outputs: ALU, branch resolution, and a multi-cycle MULTU/DIVU engine with HI/LO registers.
- Produces the registered EX/MEM payload and a stall request back toward IF/ID and ID/EX.
- Sits between ID/EX and the MEM stage. All state updates on the falling edge of clk, matching the pipeline registers.

Parameters:
- WIDTH, 32, datapath width; HI/LO width.
- ITER, 32, iterations for MULTU/DIVU; must equal WIDTH.

Ports:
- clk  in  1  pipeline clock; state updates on falling edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous kill: EX/MEM payload becomes a bubble; aborts any multi-cycle op.
- RegWriteIn, MemReadIn, MemWriteIn  in  1 each  control fields from ID/EX.
- ALUOp  in  4  operation select.
- NotEqual, IsBranch  in  1 each  branch control from ID/EX.
- ALUVal1, ALUVal2, readReg2, branchAddr  in  WIDTH each  operands, store data, and branch target.
- dest  in  5  destination register.
- RegWrite, MemRead, MemWrite  out  1 each  registered EX/MEM control.
- ALUResult, storeData  out  WIDTH each  registered result and store data.
- destOut  out  5  registered destination.
- branchTaken  out  1  registered branch-taken flag.
- branchTarget  out  WIDTH  registered branch target.
- stall  out  1  combinational; holds IF/ID and ID/EX while high.
- busy  out  1  multi-cycle engine active.

Behaviour:
- ALUOp encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: shift ALUVal2 by ALUVal1[4:0].
  - 11 LUI: ALUVal2<<16.
  - 12 MULTU, 13 DIVU, 14 MFHI, 15 MFLO.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no overflow trap. SLT/SLTU results are 0 or 1, zero-extended.
- Single-cycle ops (0-11, 14, 15): on the falling edge, the EX/MEM outputs capture the inputs and the result. Latency is 1 edge.
- MFHI/MFLO immediately after a completed MULTU/DIVU return the new HI/LO values; HI/LO are written on the DONE edge.
- Branch: branchTaken = IsBranch & ((ALUVal1==ALUVal2) ^ NotEqual), registered with the payload. branchTarget = branchAddr.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: ALUOp is 12 or 13 and flush=0. Load operands, counter=0, stall=1. EX/MEM captures a bubble (RegWrite/MemRead/MemWrite/branchTaken = 0).
  - RUN: one shift-add (MULTU) or restoring-subtract (DIVU) step per edge, counter+1. stall=1. EX/MEM keeps capturing bubbles.
  - RUN -> DONE: when counter reaches ITER-1.
  - DONE: HI/LO written (MULTU: {HI,LO} = 64-bit product; DIVU: LO = quotient, HI = remainder). stall=0. EX/MEM captures a bubble (MULTU/DIVU write no GPR). Then -> IDLE.
  - Total: stall high for exactly ITER+1 edges (the IDLE start edge plus ITER RUN edges). During stall, the upstream ID/EX holds the same MULTU/DIVU instruction.
- DIVU by zero: still takes the full latency; HI = dividend, LO = all ones.
- flush:
  - Has priority over everything, in any state.
  - On that edge: EX/MEM captures a bubble, FSM -> IDLE, HI/LO unchanged, stall drops combinationally.
- Reset: while reset=0, immediately (async) set all outputs to 0, HI = LO = 0, FSM = IDLE, counter = 0, stall = 0, busy = 0. This applies mid-operation too: a partial result is discarded.
- busy = (state != IDLE).

Test Plan:
- Reset, then ADD with ALUVal1=5, ALUVal2=7, dest=3, RegWriteIn=1 -> after 1 falling edge: ALUResult=12, destOut=3, RegWrite=1, stall=0.
- BNE with IsBranch=1, NotEqual=1, vals 4/4, branchAddr=0x40 -> branchTaken=0. Repeat with vals 4/5 -> branchTaken=1, branchTarget=0x40.
- MULTU 0xFFFFFFFF x 2 -> stall high for 33 edges, bubbles meanwhile. Then MFHI=1 and MFLO=0xFFFFFFFE.
- DIVU 100/7 -> LO=14, HI=2. Then DIVU 9/0 -> HI=9, LO=0xFFFFFFFF, full latency.
- Pull reset low at RUN edge 10 of a MULTU -> busy=0, stall=0, HI=LO=0 immediately; next ADD executes normally.
- Assert flush during RUN edge 5 of a DIVU -> FSM IDLE, stall=0, HI/LO retain prior values, EX/MEM outputs a bubble.
